// File: rtl/hilo_div_ctrl_pkg.sv
// ============================================================================
// hilo_div_ctrl_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the HI/LO multiply/divide-unit controller:
//   - DEFAULT_WIDTH : default operand / result width
//   - DIV_ITERS     : number of restoring iterations for a default-width divide
//   - OP_*          : encodings of the 2-bit op field presented by EX
//   - state_t/ST_*  : controller FSM state type and state constants
//   - is_hilo_read  : true for the ops that read HI or LO (MFHI / MFLO)
// No ports; imported by hilo_div_ctrl and div_iter_core.
// ============================================================================
package hilo_div_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // One restoring step per result bit.
    localparam int DIV_ITERS = DEFAULT_WIDTH;

    // Op field encodings from the EX stage.
    localparam logic [1:0] OP_DIVU = 2'b00;
    localparam logic [1:0] OP_MFHI = 2'b01;
    localparam logic [1:0] OP_MFLO = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Controller states, kept as plain constants so the encoding is visible
    // in waveforms and netlists without enum decoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic is_hilo_read(input logic [1:0] op_code);
        return (op_code == OP_MFHI) || (op_code == OP_MFLO);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_iter_core.sv
// ============================================================================
// div_iter_core
// ----------------------------------------------------------------------------
// Datapath of an unsigned restoring divider, one quotient bit per step.
// Holds a 2*WIDTH partial-remainder register {R, Q} and the latched divisor.
//   load : capture divisor and set {R, Q} = {0, dividend}
//   step : shift {R, Q} left; try R - divisor; keep the difference and shift
//          in 1 when it does not go negative, otherwise restore and shift in 0
// After WIDTH steps the upper half is the remainder and the lower half the
// quotient. Directly after a load (no steps) the lower half still holds the
// dividend, which the controller relies on for its divide-by-zero shortcut.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset     in   synchronous active-high reset, clears all state
//   load      in   start a new divide (has priority over step)
//   step      in   perform one restoring iteration
//   dividend  in   WIDTH  dividend captured on load
//   divisor   in   WIDTH  divisor captured on load
//   quotient  out  WIDTH  lower half of the partial-remainder register
//   remainder out  WIDTH  upper half of the partial-remainder register
// ============================================================================
module div_iter_core
    import hilo_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [2*WIDTH-1:0] rem_reg;
    logic [2*WIDTH-1:0] rem_next;
    logic [WIDTH-1:0]   divisor_reg;

    // Upper half after the left shift needs WIDTH+1 bits: the bit shifted
    // out of the remainder half takes part in the trial subtraction.
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     trial_diff;

    always_comb begin
        partial    = rem_reg[2*WIDTH-1:WIDTH-1];
        trial_diff = partial - {1'b0, divisor_reg};
        rem_next   = rem_reg;
        if (load) begin
            rem_next = {{WIDTH{1'b0}}, dividend};
        end else if (step) begin
            // Remainder stays below the divisor, so the trial difference is
            // either a valid WIDTH-bit value or wraps with its MSB set.
            if (trial_diff[WIDTH]) begin
                rem_next = {rem_reg[2*WIDTH-2:0], 1'b0};
            end else begin
                rem_next = {trial_diff[WIDTH-1:0], rem_reg[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg     <= '0;
            divisor_reg <= '0;
        end else begin
            rem_reg <= rem_next;
            if (load) begin
                divisor_reg <= divisor;
            end
        end
    end

    assign quotient  = rem_reg[WIDTH-1:0];
    assign remainder = rem_reg[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/hilo_div_ctrl.sv
// ============================================================================
// hilo_div_ctrl
// ----------------------------------------------------------------------------
// HI/LO controller for the 5-stage pipeline. Accepts DIVU / MFHI / MFLO from
// EX, runs a WIDTH-iteration unsigned restoring divide (one step per cycle)
// in div_iter_core, owns the HI (remainder) and LO (quotient) registers and
// stalls the front of the pipeline while a divide is in flight.
//
// Timing of a divide accepted at the end of cycle t:
//   BUSY t+1 .. t+WIDTH, DONE t+WIDTH+1 (hi/lo written at its end),
//   new hi/lo visible and busy low from t+WIDTH+2.
//
// Configuration macro:
//   DIV_ZERO_FAST_EN  when defined, a DIVU with src_b == 0 skips the
//                     iterations (IDLE -> DONE), giving the same result
//                     (lo = all ones, hi = dividend) at t+2.
//
// Ports:
//   clk       in   pipeline clock, all state on rising edge
//   reset     in   synchronous active-high reset (aborts any divide)
//   op_valid  in   EX presents an HI/LO-class op this cycle
//   op        in   2      00 DIVU, 01 MFHI, 10 MFLO, 11 reserved
//   src_a     in   WIDTH  dividend
//   src_b     in   WIDTH  divisor
//   stall     out  combinational; hold IF/ID/EX
//   busy      out  divide in flight (state != IDLE)
//   rd_valid  out  combinational; MFHI/MFLO result valid this cycle
//   rd_data   out  WIDTH  combinational; hi for MFHI, lo for MFLO, else 0
//   hi        out  WIDTH  HI register (remainder)
//   lo        out  WIDTH  LO register (quotient)
// ============================================================================
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_ITER  = CW'(1);

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             div_start;
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] core_quotient;
    logic [WIDTH-1:0] core_remainder;

`ifdef DIV_ZERO_FAST_EN
    // Set when the divide in flight took the zero-divisor shortcut; the core
    // then holds the untouched dividend in its lower half.
    logic             zero_fast_reg;
    logic             zero_fast_next;
`endif

    // ------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------
    assign busy      = (state_reg != ST_IDLE);
    assign stall     = op_valid && (op != OP_RSVD) && busy;
    assign rd_valid  = op_valid && is_hilo_read(op) && !busy;
    assign div_start = op_valid && (op == OP_DIVU) && !busy;

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            rd_data = (op == OP_MFHI) ? hi_reg : lo_reg;
        end
    end

    // ------------------------------------------------------------------
    // FSM and iteration counter
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        core_load  = 1'b0;
        core_step  = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zero_fast_next = zero_fast_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (div_start) begin
                    core_load  = 1'b1;
                    count_next = '0;
`ifdef DIV_ZERO_FAST_EN
                    zero_fast_next = (src_b == '0);
                    state_next     = (src_b == '0) ? ST_DONE : ST_BUSY;
`else
                    state_next = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                core_step  = 1'b1;
                count_next = count_reg + ONE_ITER;
                if (count_reg == LAST_ITER) begin
                    count_next = '0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

`ifdef DIV_ZERO_FAST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_fast_reg <= 1'b0;
        end else begin
            zero_fast_reg <= zero_fast_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // HI/LO: written as a pair only at the end of DONE, so a consumer never
    // sees a half-updated result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == ST_DONE) begin
`ifdef DIV_ZERO_FAST_EN
            if (zero_fast_reg) begin
                hi_reg <= core_quotient;
                lo_reg <= '1;
            end else begin
                hi_reg <= core_remainder;
                lo_reg <= core_quotient;
            end
`else
            hi_reg <= core_remainder;
            lo_reg <= core_quotient;
`endif
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .step      (core_step),
        .dividend  (src_a),
        .divisor   (src_b),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// ============================================================================
// tb_hilo_div_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for hilo_div_ctrl. A reference model tracks HI/LO and
// the number of cycles a divide still occupies the unit, computing results
// with plain / and %. Every cycle stall, busy, rd_valid, rd_data, hi and lo
// are compared against it. Directed scenarios come first, then random ops.
// Honors DIV_ZERO_FAST_EN for the zero-divisor latency.
// ============================================================================
module tb_hilo_div_ctrl;

    localparam int W = 32;

    // Cycles the unit stays busy after accepting a divide.
    localparam int LAT = W + 1;
`ifdef DIV_ZERO_FAST_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         stall;
    logic         busy;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    int           m_left = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_pq = '0;
    logic [W-1:0] m_pr = '0;
    logic         last_stall = 1'b0;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .stall    (stall),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check combinational and
    // registered outputs shortly after, then advance the model at the edge.
    task automatic run_cycle(input logic r, input logic v, input logic [1:0] o,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic         exp_stall;
        logic         exp_rdv;
        logic [W-1:0] exp_rdd;
        reset = r; op_valid = v; op = o; src_a = a; src_b = b;
        #1;
        exp_stall = v && (o != 2'b11) && (m_left > 0);
        exp_rdv   = v && (o == 2'b01 || o == 2'b10) && (m_left == 0);
        exp_rdd   = exp_rdv ? ((o == 2'b01) ? m_hi : m_lo) : '0;
        chk("stall", stall, exp_stall);
        chk("busy", busy, (m_left > 0));
        chk("rd_valid", rd_valid, exp_rdv);
        chk("rd_data", rd_data, exp_rdd);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        last_stall = exp_stall;
        @(posedge clk);
        if (r) begin
            m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_pr; m_lo = m_pq;
                $display("DONE lo=%h hi=%h t=%0t", m_lo, m_hi, $time);
            end
        end else if (v && o == 2'b00) begin
            m_left = (b == '0) ? LAT_ZERO : LAT;
            m_pq   = (b == '0) ? '1 : a / b;
            m_pr   = (b == '0) ? a : a % b;
            $display("DIVU %h / %h accepted t=%0t", a, b, $time);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    // Present an op and hold it while stalled, as the pipeline would.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        do begin
            run_cycle(1'b0, 1'b1, o, a, b);
            n++;
        end while (last_stall && n < 200);
        if (last_stall) chk("issue_timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   o;
        reset = 1'b1; op_valid = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);

        // Reset state, then an IDLE MFLO reads 0 without stall.
        run_cycle(1'b1, 1'b0, 2'b00, '0, '0);
        issue(2'b10, '0, '0);

        // 100 / 7
        issue(2'b00, 32'd100, 32'd7);
        idle(34);
        chk("lo_100_7", lo, 32'd14);
        chk("hi_100_7", hi, 32'd2);

        // 0xFFFFFFFF / 1 with an MFHI arriving at t+5
        issue(2'b00, 32'hFFFF_FFFF, 32'd1);
        idle(4);
        issue(2'b01, '0, '0);
        chk("lo_ffff_1", lo, 32'hFFFF_FFFF);

        // Divide by zero
        issue(2'b00, 32'd5, 32'd0);
        idle(34);
        chk("lo_5_0", lo, 32'hFFFF_FFFF);
        chk("hi_5_0", hi, 32'd5);

        // Back-to-back divides, second held until accepted
        issue(2'b00, 32'd9, 32'd2);
        issue(2'b00, 32'd20, 32'd3);
        idle(34);
        chk("lo_20_3", lo, 32'd6);
        chk("hi_20_3", hi, 32'd2);

        // Reset mid-divide aborts
        issue(2'b00, 32'd50, 32'd4);
        idle(9);
        run_cycle(1'b1, 1'b0, 2'b00, '0, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_lo", lo, 32'd0);
        issue(2'b10, '0, '0);

        // Reserved op during BUSY has no effect
        issue(2'b00, 32'd1000, 32'd3);
        idle(3);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 2'b11, 32'd1, 32'd1);
        idle(40);
        chk("lo_1000_3", lo, 32'd333);
        chk("hi_1000_3", hi, 32'd1);

        // Reset and DIVU together: reset wins
        run_cycle(1'b1, 1'b1, 2'b00, 32'd77, 32'd7);
        chk("rst_wins_busy", busy, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            o = 2'($urandom_range(0, 3));
            run_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), o, a, b);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Multiply/divide-unit controller for the 5-stage pipeline. It accepts DIVU, MFHI and MFLO operations from the EX stage and sequences a 32-iteration unsigned restoring divide, one step per cycle. It owns the HI/LO architectural registers and stalls the pipeline whenever an HI/LO consumer or a new divide arrives while a divide is in flight.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the divide runs WIDTH iterations.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- op_valid  in  1  EX stage presents an HI/LO-class op this cycle
- op  in  2  00 DIVU, 01 MFHI, 10 MFLO, 11 reserved (ignored, never stalls)
- src_a  in  WIDTH  dividend (DIVU)
- src_b  in  WIDTH  divisor (DIVU)
- stall  out  1  combinational; holds IF/ID/EX while high
- busy  out  1  divide in flight (state != IDLE)
- rd_valid  out  1  combinational; MFHI/MFLO result valid this cycle
- rd_data  out  WIDTH  combinational; hi for MFHI, lo for MFLO, 0 otherwise
- hi  out  WIDTH  HI register (remainder)
- lo  out  WIDTH  LO register (quotient)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: op_valid & op==DIVU → latch src_a/src_b, load remainder {0, src_a}, counter=0, go BUSY. MFHI/MFLO → rd_valid=1, rd_data=hi/lo, no stall.
- BUSY: one restoring step per cycle (subtract divisor from upper half; if negative restore and shift in 0, else shift in 1). Counter increments; when counter==WIDTH-1 → DONE.
- DONE: write lo=quotient, hi=remainder at end of cycle; go IDLE.
- stall = op_valid & (op != 11) & (state != IDLE). rd_valid = op_valid & op∈{MFHI,MFLO} & state==IDLE.
- A DIVU issued while busy is stalled and accepted on the first IDLE cycle; no queueing.
- Divisor 0: quotient 0xFFFF_FFFF, remainder = dividend (natural restoring result).
- hi/lo change only in DONE or reset; never partially updated.
- Reserved op: no effect, no stall, rd_valid=0.

## Timing
- Reset values: state IDLE, busy 0, hi 0, lo 0, counter 0; stall/rd_valid 0 unless an IDLE-state MFHI/MFLO is presented (rd_valid then 1, rd_data 0).
- DIVU accepted at end of cycle t: BUSY cycles t+1..t+32, DONE at t+33, new hi/lo visible and busy=0 in cycle t+34.
- busy high t+1..t+33 inclusive; a consumer presented in that window stalls and completes in t+34 with the new value.
- Reset asserted mid-divide: abort at that edge; next cycle IDLE with hi=lo=0; latched operands discarded.
- reset and op_valid in the same cycle: reset wins, op not accepted.

## Configuration
- DIV_ZERO_FAST_EN defined: DIVU with src_b==0 goes IDLE→DONE directly; results identical; hi/lo visible at t+2, busy high only in t+1.
- Not defined: divide-by-zero takes the full 34-cycle path like any other divide.

## Structure
- Shared package: WIDTH default, op encodings (OP_DIVU, OP_MFHI, OP_MFLO), state enum, iteration count constant.
- One sub-module: div_iter_core. It holds the 2·WIDTH remainder register and divisor and takes load/step inputs. It outputs quotient and remainder. The controller owns the FSM, counter, stall logic and HI/LO.

## Test plan
- DIVU 100/7 at t → busy t+1..t+33; at t+34 lo=14, hi=2.
- DIVU 0xFFFF_FFFF/1, then MFHI at t+5 → stall high t+5..t+33; t+34 rd_valid=1, rd_data=0; lo=0xFFFF_FFFF.
- DIVU 5/0 → lo=0xFFFF_FFFF, hi=5 at t+34 (without macro) or t+2 (with DIV_ZERO_FAST_EN).
- Back-to-back DIVU 9/2 then 20/3 → second stalled, accepted at t+34; final lo=6, hi=2 at t+68.
- Reset pulsed at t+10 during DIVU 50/4 → t+11 busy=0, hi=lo=0; a subsequent MFLO reads 0 without stall.
- Reserved op 11 with op_valid during BUSY → stall=0, rd_valid=0, divide result unaffected.
